// File: rtl/cdb_arbiter.sv
// cdb_arbiter: three per-producer result FIFOs (ALU, BRU, LDU) sharing one
// registered common data bus through a round-robin scheduler. A
// misprediction flush clears everything in flight.
module cdb_arbiter #(
  parameter int ROB_BIT = 5,
  parameter int DAT_W   = 32,
  parameter int BUF_D   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               flush_i,
  input  logic               alu_vld_i,
  input  logic [ROB_BIT-1:0] alu_q_i,
  input  logic [DAT_W-1:0]   alu_v_i,
  output logic               alu_rdy_o,
  input  logic               bru_vld_i,
  input  logic [ROB_BIT-1:0] bru_q_i,
  input  logic [DAT_W-1:0]   bru_v_i,
  input  logic               bru_cbr_i,
  input  logic [DAT_W-1:0]   bru_cbt_i,
  output logic               bru_rdy_o,
  input  logic               ldu_vld_i,
  input  logic [ROB_BIT-1:0] ldu_q_i,
  input  logic [DAT_W-1:0]   ldu_v_i,
  output logic               ldu_rdy_o,
  output logic               cdb_en_o,
  output logic [ROB_BIT-1:0] cdb_q_o,
  output logic [DAT_W-1:0]   cdb_v_o,
  output logic               cdb_cbr_o,
  output logic [DAT_W-1:0]   cdb_cbt_o,
  output logic               busy_o
);
  localparam int PW = $clog2(BUF_D);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(BUF_D);

  typedef struct packed {
    logic [ROB_BIT-1:0] q;
    logic [DAT_W-1:0]   v;
    logic               cbr;
    logic [DAT_W-1:0]   cbt;
  } ent_t;

  // Source index: 0=ALU, 1=BRU, 2=LDU.
  ent_t          mem_q    [3][BUF_D];
  logic [PW-1:0] wr_ptr_q [3];
  logic [PW-1:0] wr_ptr_d [3];
  logic [PW-1:0] rd_ptr_q [3];
  logic [PW-1:0] rd_ptr_d [3];
  logic [CW-1:0] cnt_q    [3];
  logic [CW-1:0] cnt_d    [3];
  logic [1:0]    rr_q, rr_d;
  logic          cdb_en_q, cdb_en_d;
  ent_t          cdb_ent_q, cdb_ent_d;

  ent_t          push_ent [3];
  logic [2:0]    vld, rdy, push, pop, nonempty;
  logic [1:0]    win;
  logic          win_vld;

  // Pack producer inputs into FIFO entries; tag 0 is handshaken but never stored.
  always_comb begin
    push_ent[0]     = '0;
    push_ent[0].q   = alu_q_i;
    push_ent[0].v   = alu_v_i;
    push_ent[1]     = '0;
    push_ent[1].q   = bru_q_i;
    push_ent[1].v   = bru_v_i;
    push_ent[1].cbr = bru_cbr_i;
    push_ent[1].cbt = bru_cbt_i;
    push_ent[2]     = '0;
    push_ent[2].q   = ldu_q_i;
    push_ent[2].v   = ldu_v_i;
    vld             = {ldu_vld_i, bru_vld_i, alu_vld_i};
    for (int s = 0; s < 3; s++) begin
      nonempty[s] = (cnt_q[s] != '0);
      rdy[s]      = en & (cnt_q[s] < DEPTH);
      push[s]     = vld[s] & rdy[s] & (push_ent[s].q != '0);
    end
  end

  // Round-robin search starting at rr; first non-empty FIFO wins.
  always_comb begin
    logic [2:0] sum;
    win     = rr_q;
    win_vld = 1'b0;
    sum     = '0;
    for (int k = 0; k < 3; k++) begin
      sum = {1'b0, rr_q} + 3'(k);
      if (sum >= 3'd3) sum = sum - 3'd3;
      if (!win_vld && nonempty[sum[1:0]]) begin
        win     = sum[1:0];
        win_vld = 1'b1;
      end
    end
    pop = win_vld ? (3'b001 << win) : 3'b000;
  end

  // Next-state for pointers, counts, rr and the broadcast register (applied only when enabled).
  always_comb begin
    for (int s = 0; s < 3; s++) begin
      wr_ptr_d[s] = wr_ptr_q[s] + PW'(push[s]);
      rd_ptr_d[s] = rd_ptr_q[s] + PW'(pop[s]);
      cnt_d[s]    = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
    end
    rr_d      = rr_q;
    cdb_en_d  = 1'b0;
    cdb_ent_d = '0;
    if (win_vld) begin
      rr_d      = (win == 2'd2) ? 2'd0 : win + 2'd1;
      cdb_en_d  = 1'b1;
      cdb_ent_d = mem_q[win][rd_ptr_q[win]];
    end
  end

  // Control and broadcast registers: rst/flush clear, en gates every update.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      for (int s = 0; s < 3; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
      rr_q      <= 2'd0;
      cdb_en_q  <= 1'b0;
      cdb_ent_q <= '0;
    end else if (en) begin
      for (int s = 0; s < 3; s++) begin
        wr_ptr_q[s] <= wr_ptr_d[s];
        rd_ptr_q[s] <= rd_ptr_d[s];
        cnt_q[s]    <= cnt_d[s];
      end
      rr_q      <= rr_d;
      cdb_en_q  <= cdb_en_d;
      cdb_ent_q <= cdb_ent_d;
    end
  end

  // FIFO storage has no reset; occupancy is tracked by the counts alone.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i) begin
      for (int s = 0; s < 3; s++) begin
        if (push[s]) mem_q[s][wr_ptr_q[s]] <= push_ent[s];
      end
    end
  end

  assign alu_rdy_o = rdy[0];
  assign bru_rdy_o = rdy[1];
  assign ldu_rdy_o = rdy[2];
  assign busy_o    = |nonempty;
  assign cdb_en_o  = cdb_en_q;
  assign cdb_q_o   = cdb_ent_q.q;
  assign cdb_v_o   = cdb_ent_q.v;
  assign cdb_cbr_o = cdb_ent_q.cbr;
  assign cdb_cbt_o = cdb_ent_q.cbt;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cdb_arbiter;
  localparam int RB = 5;
  localparam int DW = 32;
  localparam int BD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, flush_i;
  logic          alu_vld_i, bru_vld_i, ldu_vld_i, bru_cbr_i;
  logic [RB-1:0] alu_q_i, bru_q_i, ldu_q_i;
  logic [DW-1:0] alu_v_i, bru_v_i, bru_cbt_i, ldu_v_i;
  logic          alu_rdy_o, bru_rdy_o, ldu_rdy_o;
  logic          cdb_en_o, cdb_cbr_o, busy_o;
  logic [RB-1:0] cdb_q_o;
  logic [DW-1:0] cdb_v_o, cdb_cbt_o;

  cdb_arbiter #(.ROB_BIT(RB), .DAT_W(DW), .BUF_D(BD)) dut (
    .clk(clk), .rst(rst), .en(en), .flush_i(flush_i),
    .alu_vld_i(alu_vld_i), .alu_q_i(alu_q_i), .alu_v_i(alu_v_i), .alu_rdy_o(alu_rdy_o),
    .bru_vld_i(bru_vld_i), .bru_q_i(bru_q_i), .bru_v_i(bru_v_i), .bru_cbr_i(bru_cbr_i),
    .bru_cbt_i(bru_cbt_i), .bru_rdy_o(bru_rdy_o),
    .ldu_vld_i(ldu_vld_i), .ldu_q_i(ldu_q_i), .ldu_v_i(ldu_v_i), .ldu_rdy_o(ldu_rdy_o),
    .cdb_en_o(cdb_en_o), .cdb_q_o(cdb_q_o), .cdb_v_o(cdb_v_o), .cdb_cbr_o(cdb_cbr_o),
    .cdb_cbt_o(cdb_cbt_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [RB-1:0] q;
    logic [DW-1:0] v;
    logic          cbr;
    logic [DW-1:0] cbt;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  ent_t q2[$];
  int   rr;
  logic          m_en, m_cbr;
  logic [RB-1:0] m_q;
  logic [DW-1:0] m_v, m_cbt;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int s);
    if (s == 0) return q0.size();
    if (s == 1) return q1.size();
    return q2.size();
  endfunction

  task automatic qpop(input int s, output ent_t e);
    if (s == 0) e = q0.pop_front();
    else if (s == 1) e = q1.pop_front();
    else e = q2.pop_front();
  endtask

  task automatic qpush(input int s, input ent_t e);
    if (s == 0) q0.push_back(e);
    else if (s == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask

  // Reference model: advances one clock edge using the inputs applied before it.
  task automatic model_step();
    int   sz[3];
    bit   pv[3];
    ent_t pe[3];
    ent_t e;
    int   w;
    if (rst || flush_i) begin
      q0.delete(); q1.delete(); q2.delete();
      rr = 0; m_en = 0; m_q = 0; m_v = 0; m_cbr = 0; m_cbt = 0;
    end else if (en) begin
      for (int s = 0; s < 3; s++) sz[s] = qsize(s);
      pe[0] = '{alu_q_i, alu_v_i, 1'b0, '0};
      pe[1] = '{bru_q_i, bru_v_i, bru_cbr_i, bru_cbt_i};
      pe[2] = '{ldu_q_i, ldu_v_i, 1'b0, '0};
      pv[0] = alu_vld_i; pv[1] = bru_vld_i; pv[2] = ldu_vld_i;
      w = -1;
      for (int k = 0; k < 3; k++)
        if (w < 0 && sz[(rr + k) % 3] > 0) w = (rr + k) % 3;
      if (w >= 0) begin
        qpop(w, e);
        m_en = 1; m_q = e.q; m_v = e.v; m_cbr = e.cbr; m_cbt = e.cbt;
        rr = (w + 1) % 3;
      end else begin
        m_en = 0; m_q = 0; m_v = 0; m_cbr = 0; m_cbt = 0;
      end
      for (int s = 0; s < 3; s++)
        if (pv[s] && sz[s] < BD && pe[s].q != 0) qpush(s, pe[s]);
    end
  endtask

  task automatic compare();
    chk("cdb_en", 64'(cdb_en_o), 64'(m_en));
    chk("cdb_q", 64'(cdb_q_o), 64'(m_q));
    chk("cdb_v", 64'(cdb_v_o), 64'(m_v));
    chk("cdb_cbr", 64'(cdb_cbr_o), 64'(m_cbr));
    chk("cdb_cbt", 64'(cdb_cbt_o), 64'(m_cbt));
    chk("alu_rdy", 64'(alu_rdy_o), 64'(en && q0.size() < BD));
    chk("bru_rdy", 64'(bru_rdy_o), 64'(en && q1.size() < BD));
    chk("ldu_rdy", 64'(ldu_rdy_o), 64'(en && q2.size() < BD));
    chk("busy", 64'(busy_o), 64'(q0.size() + q1.size() + q2.size() > 0));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic clear_vld();
    alu_vld_i = 0; bru_vld_i = 0; ldu_vld_i = 0;
  endtask

  task automatic do_flush();
    flush_i = 1; cycle(); flush_i = 0;
  endtask

  initial begin
    int      ai, seen;
    bit      acc, saw_full;
    int      got[$];
    rst = 1; en = 1; flush_i = 0;
    alu_vld_i = 0; alu_q_i = 0; alu_v_i = 0;
    bru_vld_i = 0; bru_q_i = 0; bru_v_i = 0; bru_cbr_i = 0; bru_cbt_i = 0;
    ldu_vld_i = 0; ldu_q_i = 0; ldu_v_i = 0;
    rr = 0; m_en = 0; m_q = 0; m_v = 0; m_cbr = 0; m_cbt = 0;
    cycle(); cycle();
    rst = 0;

    // Reset then idle
    cycle();
    chk("idle_en", 64'(cdb_en_o), 0);
    chk("idle_alu_rdy", 64'(alu_rdy_o), 1);
    chk("idle_bru_rdy", 64'(bru_rdy_o), 1);
    chk("idle_ldu_rdy", 64'(ldu_rdy_o), 1);
    chk("idle_busy", 64'(busy_o), 0);

    // Single ALU push, visible in cycle 2 only
    alu_vld_i = 1; alu_q_i = 3; alu_v_i = 32'h11;
    cycle(); clear_vld();
    chk("single_c1_en", 64'(cdb_en_o), 0);
    cycle();
    chk("single_en", 64'(cdb_en_o), 1);
    chk("single_q", 64'(cdb_q_o), 3);
    chk("single_v", 64'(cdb_v_o), 64'h11);
    chk("single_cbr", 64'(cdb_cbr_o), 0);
    chk("single_cbt", 64'(cdb_cbt_o), 0);
    cycle();
    chk("single_c3_en", 64'(cdb_en_o), 0);

    // All three at once: round-robin order from rr=0
    do_flush();
    alu_vld_i = 1; alu_q_i = 1; alu_v_i = 32'hA1;
    bru_vld_i = 1; bru_q_i = 2; bru_v_i = 32'hB2; bru_cbr_i = 1; bru_cbt_i = 32'h100;
    ldu_vld_i = 1; ldu_q_i = 4; ldu_v_i = 32'hC4;
    cycle(); clear_vld(); bru_cbr_i = 0; bru_cbt_i = 0;
    cycle();
    chk("rr_c2_q", 64'(cdb_q_o), 1);
    chk("rr_c2_cbr", 64'(cdb_cbr_o), 0);
    cycle();
    chk("rr_c3_q", 64'(cdb_q_o), 2);
    chk("rr_c3_cbr", 64'(cdb_cbr_o), 1);
    chk("rr_c3_cbt", 64'(cdb_cbt_o), 64'h100);
    cycle();
    chk("rr_c4_q", 64'(cdb_q_o), 4);
    chk("rr_c4_cbt", 64'(cdb_cbt_o), 0);

    // ALU backpressure while BRU/LDU keep the bus busy
    do_flush();
    ai = 0; saw_full = 0; got.delete();
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      alu_vld_i = (ai < 4); alu_q_i = RB'(5 + ai); alu_v_i = 32'(ai);
      bru_vld_i = 1; bru_q_i = RB'(16 + c % 8); bru_v_i = 32'(c);
      ldu_vld_i = 1; ldu_q_i = RB'(24 + c % 8); ldu_v_i = 32'(c);
      acc = alu_vld_i && alu_rdy_o;
      if (alu_vld_i && !alu_rdy_o) saw_full = 1;
      cycle();
      if (acc) ai++;
      if (cdb_en_o && cdb_q_o >= 5 && cdb_q_o <= 8) got.push_back(int'(cdb_q_o));
    end
    clear_vld();
    chk("bp_rdy_dropped", 64'(saw_full), 1);
    chk("bp_count", 64'(got.size()), 4);
    for (int i = 0; i < 4; i++)
      chk("bp_order", 64'(i < got.size() ? got[i] : -1), 64'(5 + i));

    // Flush with two buffered entries plus a same-cycle push
    do_flush();
    alu_vld_i = 1; alu_q_i = 11; bru_vld_i = 1; bru_q_i = 12;
    cycle(); clear_vld();
    flush_i = 1; ldu_vld_i = 1; ldu_q_i = 13;
    cycle(); flush_i = 0; clear_vld();
    chk("flush_en", 64'(cdb_en_o), 0);
    chk("flush_busy", 64'(busy_o), 0);
    chk("flush_rdy", 64'({alu_rdy_o, bru_rdy_o, ldu_rdy_o}), 64'h7);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (cdb_en_o) seen++;
    end
    chk("flush_no_bcast", 64'(seen), 0);

    // en=0 holds the broadcast and drops readiness
    alu_vld_i = 1; alu_q_i = 9; alu_v_i = 32'h99;
    ldu_vld_i = 1; ldu_q_i = 10; ldu_v_i = 32'hAA;
    cycle(); clear_vld();
    cycle();
    chk("hold_pre_q", 64'(cdb_q_o), 9);
    en = 0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("hold_en", 64'(cdb_en_o), 1);
      chk("hold_q", 64'(cdb_q_o), 9);
      chk("hold_rdy", 64'({alu_rdy_o, bru_rdy_o, ldu_rdy_o}), 0);
    end
    en = 1;
    cycle();
    chk("resume_q", 64'(cdb_q_o), 10);
    chk("resume_v", 64'(cdb_v_o), 64'hAA);

    // Tag-0 push is accepted but never broadcast
    alu_vld_i = 1; alu_q_i = 0; alu_v_i = 32'h55;
    cycle(); clear_vld();
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (cdb_en_o) seen++;
    end
    chk("tag0_no_bcast", 64'(seen), 0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 199) == 0);
      flush_i = ($urandom_range(0, 39) == 0);
      en      = ($urandom_range(0, 9) != 0);
      alu_vld_i = $urandom_range(0, 1); alu_q_i = RB'($urandom_range(0, 31)); alu_v_i = $urandom;
      bru_vld_i = $urandom_range(0, 1); bru_q_i = RB'($urandom_range(0, 31)); bru_v_i = $urandom;
      bru_cbr_i = $urandom_range(0, 1); bru_cbt_i = $urandom;
      ldu_vld_i = $urandom_range(0, 1); ldu_q_i = RB'($urandom_range(0, 31)); ldu_v_i = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
